// File: rtl/rlgl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rlgl_pkg
//  Description : Shared types and constants for the Red Light, Green Light
//                phase controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package rlgl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GREEN = 2'd1,
    WARN  = 2'd2,
    RED   = 2'd3
  } light_state_t;

  // Width of the unit countdown and round counter.
  localparam int UNIT_W = 8;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [UNIT_W-1:0] sat_inc(input logic [UNIT_W-1:0] v);
    return (v == {UNIT_W{1'b1}}) ? v : v + UNIT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/light_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler counting 0..TICK_DIV-1; tick is high on the last
//                count. A synchronous clear restarts the count from zero so
//                each phase begins on a unit boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  assign tick_o = (div_cnt_q == LAST);

  // Next count: clear wins, otherwise wrap on the last count.
  always_comb begin
    div_cnt_d = div_cnt_q + CNT_W'(1);
    if (clr_i || tick_o) begin
      div_cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/light_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : light_sequencer
//  Description : Sequences the game light through GREEN, WARN and RED with
//                pseudo-random green/red lengths drawn from rand_in at phase
//                entry. Drives registered one-hot lights, a phase-entry pulse,
//                the remaining unit count and a saturating round counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module light_sequencer
  import rlgl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned MIN_GREEN  = 2,
  parameter int unsigned MIN_RED    = 2,
  parameter int unsigned WARN_UNITS = 1,
  parameter int unsigned RAND_BITS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       rand_in,
  output logic              green,
  output logic              warn,
  output logic              red,
  output logic              phase_start,
  output logic [UNIT_W-1:0] units_left,
  output logic [UNIT_W-1:0] round
);

  light_state_t      state_q, state_d;
  logic [UNIT_W-1:0] units_q, units_d;
  logic [UNIT_W-1:0] round_q, round_d;
  logic              green_q, green_d;
  logic              warn_q, warn_d;
  logic              red_q, red_d;
  logic              phase_start_q, phase_start_d;
  logic              clr_div;
  logic              tick;
  logic              expire;
  logic [UNIT_W-1:0] green_len;
  logic [UNIT_W-1:0] red_len;
  logic              unused_rand;

  // Phase lengths from the current LFSR sample; the parameter bounds keep
  // these sums inside 8 bits.
  assign green_len = UNIT_W'(MIN_GREEN) + UNIT_W'(rand_in[RAND_BITS-1:0]);
  assign red_len   = UNIT_W'(MIN_RED)   + UNIT_W'(rand_in[RAND_BITS+7:8]);
  assign unused_rand = ^{rand_in[15:RAND_BITS+8], rand_in[7:RAND_BITS]};

  assign expire = tick && (units_q == UNIT_W'(1));

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (clr_div),
    .tick_o (tick)
  );

  // Next-state, countdown and output decode; stop overrides expiry.
  always_comb begin
    state_d       = state_q;
    units_d       = units_q;
    round_d       = round_q;
    phase_start_d = 1'b0;
    clr_div       = 1'b0;

    if (state_q == IDLE) begin
      clr_div = 1'b1;
      if (start && !stop) begin
        state_d       = GREEN;
        units_d       = green_len;
        round_d       = '0;
        phase_start_d = 1'b1;
      end
    end else if (stop) begin
      state_d = IDLE;
      units_d = '0;
      clr_div = 1'b1;
    end else if (expire) begin
      phase_start_d = 1'b1;
      clr_div       = 1'b1;
      case (state_q)
        GREEN: begin
          state_d = WARN;
          units_d = UNIT_W'(WARN_UNITS);
        end
        WARN: begin
          state_d = RED;
          units_d = red_len;
        end
        default: begin
          state_d = GREEN;
          units_d = green_len;
          round_d = sat_inc(round_q);
        end
      endcase
    end else if (tick) begin
      units_d = units_q - UNIT_W'(1);
    end

    green_d = (state_d == GREEN);
    warn_d  = (state_d == WARN);
    red_d   = (state_d == RED);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      units_q       <= '0;
      round_q       <= '0;
      green_q       <= 1'b0;
      warn_q        <= 1'b0;
      red_q         <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      units_q       <= units_d;
      round_q       <= round_d;
      green_q       <= green_d;
      warn_q        <= warn_d;
      red_q         <= red_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign green       = green_q;
  assign warn        = warn_q;
  assign red         = red_q;
  assign phase_start = phase_start_q;
  assign units_left  = units_q;
  assign round       = round_q;

endmodule
`default_nettype wire

// File: tb/tb_light_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_sequencer
//  Description : Self-checking bench for light_sequencer with a cycle-count
//                reference model of the phase sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_light_sequencer;

  localparam int TD    = 4;
  localparam int MIN_G = 2;
  localparam int MIN_R = 3;
  localparam int WARN  = 1;
  localparam int RB    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] rand_in = 16'h0000;
  logic        green, warn, red, phase_start;
  logic [7:0]  units_left, round;

  int errors = 0;
  int checks = 0;

  // Reference model: phase (0 idle, 1 green, 2 warn, 3 red), clock cycles
  // remaining in the phase, round count and entry pulse.
  int m_phase = 0;
  int m_rem   = 0;
  int m_round = 0;
  bit m_ps    = 1'b0;

  light_sequencer #(
    .TICK_DIV(TD), .MIN_GREEN(MIN_G), .MIN_RED(MIN_R),
    .WARN_UNITS(WARN), .RAND_BITS(RB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rand_in(rand_in),
    .green(green), .warn(warn), .red(red), .phase_start(phase_start),
    .units_left(units_left), .round(round)
  );

  always #5 clk = ~clk;

  function automatic int green_cycles(input logic [15:0] r);
    return (MIN_G + (r % (1 << RB))) * TD;
  endfunction

  function automatic int red_cycles(input logic [15:0] r);
    return (MIN_R + ((r >> 8) % (1 << RB))) * TD;
  endfunction

  function automatic logic [19:0] exp_vec();
    int u;
    u = (m_phase == 0) ? 0 : (m_rem + TD - 1) / TD;
    return {m_phase == 1, m_phase == 2, m_phase == 3, m_ps, 8'(u), 8'(m_round)};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {green, warn, red, phase_start, units_left, round};
  endfunction

  // Advance one clock edge, update the model from the sampled inputs, then
  // settle 1 time unit past the edge for observation.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      m_phase = 0; m_rem = 0; m_round = 0; m_ps = 1'b0;
    end else if (m_phase == 0) begin
      m_ps = 1'b0;
      if (start && !stop) begin
        m_phase = 1; m_rem = green_cycles(rand_in); m_round = 0; m_ps = 1'b1;
      end
    end else if (stop) begin
      m_phase = 0; m_rem = 0; m_ps = 1'b0;
    end else begin
      m_rem = m_rem - 1;
      m_ps  = 1'b0;
      if (m_rem == 0) begin
        m_ps = 1'b1;
        if (m_phase == 1) begin
          m_phase = 2; m_rem = WARN * TD;
        end else if (m_phase == 2) begin
          m_phase = 3; m_rem = red_cycles(rand_in);
        end else begin
          m_phase = 1; m_rem = green_cycles(rand_in);
          m_round = (m_round == 255) ? 255 : m_round + 1;
        end
      end
    end
    #1;
  endtask

  task automatic go_idle();
    stop = 1'b1; start = 1'b0;
    cycle();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_in = 16'($urandom);
      cycle();
      checks++;
      if (dut_vec() !== 20'h0) begin
        errors++;
        $display("FAIL reset_state: got %h want %h", dut_vec(), 20'h0);
      end
    end
    reset = 1'b0;
    rand_in = 16'($urandom);
    cycle();
    checks++;
    if (green !== 1'b1 || phase_start !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release_green: got %h want %h", dut_vec(), exp_vec());
    end
    start = 1'b0;
  endtask

  // Run one full green/warn/red sequence with a fixed rand_in and check
  // every cycle plus the measured phase lengths.
  task automatic test_durations(input logic [15:0] r, input int exp_g_units,
                                input int exp_r_units);
    int gc = 0, wc = 0, rc = 0;
    go_idle();
    rand_in = r; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (units_left !== 8'(exp_g_units) || green !== 1'b1) begin
      errors++;
      $display("FAIL green_load: got units=%0d green=%b want units=%0d green=1",
               units_left, green, exp_g_units);
    end
    for (int i = 0; i < (exp_g_units + WARN + exp_r_units) * TD; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL seq_r%h_cyc%0d: got %h want %h", r, i, dut_vec(), exp_vec());
      end
      if (green) gc++;
      if (warn) wc++;
      if (red) rc++;
      if (red && rc == 1) begin
        checks++;
        if (units_left !== 8'(exp_r_units) || phase_start !== 1'b1) begin
          errors++;
          $display("FAIL red_load: got units=%0d ps=%b want units=%0d ps=1",
                   units_left, phase_start, exp_r_units);
        end
      end
      cycle();
    end
    checks++;
    if (gc != exp_g_units * TD || wc != WARN * TD || rc != exp_r_units * TD) begin
      errors++;
      $display("FAIL phase_lengths: got g=%0d w=%0d r=%0d want g=%0d w=%0d r=%0d",
               gc, wc, rc, exp_g_units * TD, WARN * TD, exp_r_units * TD);
    end
    checks++;
    if (green !== 1'b1 || round !== 8'd1 || phase_start !== 1'b1) begin
      errors++;
      $display("FAIL regreen_round: got green=%b round=%0d ps=%b want 1 1 1",
               green, round, phase_start);
    end
  endtask

  task automatic test_stop_at_expiry();
    int budget = 400;
    logic [7:0] saved;
    go_idle();
    rand_in = 16'($urandom); start = 1'b1;
    cycle();
    start = 1'b0;
    // Run into the second RED so round is non-zero, stopping on its last cycle.
    while (!(m_phase == 3 && m_rem == 1 && m_round == 1) && budget > 0) begin
      rand_in = 16'($urandom);
      cycle();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL stop_wait_timeout: got no red expiry want red expiry");
    end
    saved = round;
    stop = 1'b1; start = 1'b1; rand_in = 16'($urandom);
    cycle();
    checks++;
    if ({green, warn, red, phase_start, units_left} !== 12'h0 || round !== saved
        || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stop_on_expiry: got %h round=%0d want lights/units 0 round=%0d",
               dut_vec(), round, saved);
    end
    cycle();
    checks++;
    if (dut_vec() !== {12'h0, saved}) begin
      errors++;
      $display("FAIL stop_and_start_idle: got %h want %h", dut_vec(), {12'h0, saved});
    end
    stop = 1'b0; start = 1'b0;
  endtask

  task automatic test_start_in_green();
    int glen, gc = 0;
    go_idle();
    rand_in = 16'($urandom); start = 1'b1;
    glen = green_cycles(rand_in);
    cycle();
    while (green === 1'b1 && gc < 100) begin
      gc++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL start_in_green_cyc%0d: got %h want %h", gc, dut_vec(), exp_vec());
      end
      start = 1'($urandom);
      rand_in = 16'($urandom);
      cycle();
    end
    start = 1'b0;
    checks++;
    if (gc != glen || warn !== 1'b1) begin
      errors++;
      $display("FAIL start_in_green_len: got %0d warn=%b want %0d warn=1", gc, warn, glen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom % 4) == 0;
      stop    = ($urandom % 40) == 0;
      rand_in = 16'($urandom);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_saturation();
    int budget = 260 * 24 + 100;
    go_idle();
    rand_in = 16'h0000; start = 1'b1;
    cycle();
    start = 1'b0;
    while (!(m_round == 255 && m_ps && m_phase == 1 && budget < 2 * 24 + 100)
           && budget > 0) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL saturate_cyc: got %h want %h", dut_vec(), exp_vec());
      end
      cycle();
      budget--;
    end
    checks++;
    if (budget == 0 || round !== 8'd255) begin
      errors++;
      $display("FAIL round_saturate: got %0d want 255", round);
    end
    go_idle();
    start = 1'b1; rand_in = 16'($urandom);
    cycle();
    start = 1'b0;
    checks++;
    if (round !== 8'd0 || green !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL round_clear: got round=%0d green=%b want 0 1", round, green);
    end
  endtask

  initial begin
    test_reset();
    test_durations(16'hACE1, 3, 3);
    test_durations(16'h0303, 5, 6);
    test_stop_at_expiry();
    test_start_in_green();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
